// File: rtl/serial_router.sv
// Serial word entry by two debounced-free push keys, routed by channel field into per-channel shift buffers.
// Latency: word visible on word_o/buf_o one cycle after DELIVER; rd_data/rd_valid one cycle after rd_en.
// Backpressure: none; a full channel drops its oldest entry and counts the loss in drop_cnt.
module serial_router #(
  parameter int CH_BITS = 2,
  parameter int PAY_W   = 2,
  parameter int DEPTH   = 6,
  parameter int ARM_CYC = 3,
  parameter int CNT_W   = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic                                          key0,
  input  logic                                          key1,
  input  logic                                          rd_en,
  input  logic [CH_BITS-1:0]                            rd_ch,
  output logic [PAY_W-1:0]                              rd_data,
  output logic                                          rd_valid,
  output logic [(2**CH_BITS)*DEPTH*(PAY_W+1)-1:0]       buf_o,
  output logic [CH_BITS+PAY_W-1:0]                      word_o,
  output logic                                          word_stb,
  output logic [CNT_W-1:0]                              drop_cnt,
  output logic [CNT_W-1:0]                              rx_cnt
);

  localparam int NCH = 2**CH_BITS;
  localparam int W   = CH_BITS + PAY_W;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AW  = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
  localparam int BW  = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, ARM, COLLECT, DELIVER} state_t;

  state_t            state, state_nxt;
  logic [1:0]        k0_sync, k1_sync;
  logic              k0_prev, k1_prev;
  logic              k0_s, k1_s;
  logic              press0, press1, press_vld;
  logic [AW-1:0]     arm_cnt;
  logic              arm_done;
  logic [BW-1:0]     bit_cnt;
  logic [W-1:0]      sh;
  logic              deliver, shift_en;
  logic [CH_BITS-1:0] wr_ch;
  logic [PAY_W-1:0]  wr_pay;
  logic              pop_ok;
  logic              drop_inc;

  logic [PAY_W-1:0]  pay     [NCH][DEPTH];
  logic [PAY_W-1:0]  nxt_pay [NCH][DEPTH];
  logic [CW-1:0]     cnt     [NCH];
  logic [CW-1:0]     nxt_cnt [NCH];

  // A third flop per key holds the previous synchronised level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k0_sync <= 2'b11;
      k1_sync <= 2'b11;
      k0_prev <= 1'b1;
      k1_prev <= 1'b1;
    end else begin
      k0_sync <= {k0_sync[0], key0};
      k1_sync <= {k1_sync[0], key1};
      k0_prev <= k0_sync[1];
      k1_prev <= k1_sync[1];
    end
  end

  assign k0_s      = k0_sync[1];
  assign k1_s      = k1_sync[1];
  assign press0    = k0_prev & ~k0_s & k1_s;
  assign press1    = k1_prev & ~k1_s & k0_s;
  assign press_vld = press0 | press1;
  assign arm_done  = (arm_cnt == AW'(ARM_CYC - 1));

  always_comb begin
    state_nxt = state;
    deliver   = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = ARM;
      ARM: begin
        if (!start)        state_nxt = IDLE;
        else if (arm_done) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (!start) begin
          state_nxt = IDLE;
        end else if (press_vld) begin
          shift_en = 1'b1;
          if (bit_cnt == BW'(W - 1)) state_nxt = DELIVER;
        end
      end
      DELIVER: begin
        deliver   = 1'b1;
        state_nxt = start ? ARM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      arm_cnt  <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      word_o   <= '0;
      word_stb <= 1'b0;
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      arm_cnt  <= (state == ARM) ? arm_cnt + AW'(1) : '0;
      word_stb <= deliver;
      if (state == IDLE || state == ARM) begin
        sh      <= '0;
        bit_cnt <= '0;
      end else if (shift_en) begin
        sh      <= {sh[W-2:0], press1};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (deliver) word_o <= sh;
      if (deliver && rx_cnt != '1) rx_cnt <= rx_cnt + CNT_W'(1);
      if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign wr_ch  = sh[W-1:PAY_W];
  assign wr_pay = sh[PAY_W-1:0];
  assign pop_ok = rd_en && (cnt[rd_ch] != '0);

  // Pop is applied before the write so a simultaneous pop frees room in a full channel.
  always_comb begin
    nxt_pay  = pay;
    nxt_cnt  = cnt;
    drop_inc = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (pop_ok && rd_ch == CH_BITS'(c)) begin
        for (int e = 0; e < DEPTH - 1; e++) nxt_pay[c][e] = nxt_pay[c][e+1];
        nxt_pay[c][DEPTH-1] = '0;
        nxt_cnt[c] = nxt_cnt[c] - CW'(1);
      end
      if (deliver && wr_ch == CH_BITS'(c)) begin
        if (nxt_cnt[c] == CW'(DEPTH)) begin
          for (int e = 0; e < DEPTH - 1; e++) nxt_pay[c][e] = nxt_pay[c][e+1];
          nxt_pay[c][DEPTH-1] = wr_pay;
          drop_inc = 1'b1;
        end else begin
          for (int e = 0; e < DEPTH; e++) begin
            if (CW'(e) == nxt_cnt[c]) nxt_pay[c][e] = wr_pay;
          end
          nxt_cnt[c] = nxt_cnt[c] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        cnt[c] <= '0;
        for (int e = 0; e < DEPTH; e++) pay[c][e] <= '0;
      end
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      pay      <= nxt_pay;
      cnt      <= nxt_cnt;
      rd_valid <= pop_ok;
      if (pop_ok) rd_data <= pay[rd_ch][0];
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      assign buf_o[(c*DEPTH+e)*(PAY_W+1) +: PAY_W+1] = {pay[c][e], (CW'(e) < cnt[c])};
    end
  end

endmodule

// File: tb/tb_serial_router.sv
// Random and directed stimulus for serial_router checked against a single arrival-ordered word queue.
module tb_serial_router;
  localparam int DEPTH = 6;
  localparam int NCH   = 4;
  localparam int EW    = 3;
  localparam int BUFW  = NCH * DEPTH * EW;

  logic            clk = 1'b0;
  logic            rst_n, start, key0, key1, rd_en;
  logic [1:0]      rd_ch;
  logic [1:0]      rd_data;
  logic            rd_valid;
  logic [BUFW-1:0] buf_o;
  logic [3:0]      word_o;
  logic            word_stb;
  logic [7:0]      drop_cnt, rx_cnt;

  serial_router #(.CH_BITS(2), .PAY_W(2), .DEPTH(DEPTH), .ARM_CYC(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key0(key0), .key1(key1),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
    .buf_o(buf_o), .word_o(word_o), .word_stb(word_stb),
    .drop_cnt(drop_cnt), .rx_cnt(rx_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference: every stored word in arrival order; a channel's buffer is its words filtered in order.
  logic [3:0] mq[$];
  int         m_rx, m_drop;
  logic [1:0] m_rd;
  logic       e_rv;
  logic [1:0] e_rd;

  logic       s_rv, s_stb;
  logic [1:0] s_rd;
  int         stb_cnt = 0;
  int         stb_dbl = 0;
  logic       stb_prev = 1'b0;

  always @(negedge clk) begin
    if (word_stb) stb_cnt++;
    if (word_stb && stb_prev) stb_dbl++;
    stb_prev = word_stb;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int m_count(input logic [1:0] c);
    int n = 0;
    for (int i = 0; i < mq.size(); i++) if (mq[i][3:2] == c) n++;
    return n;
  endfunction

  function automatic logic [BUFW-1:0] m_buf();
    logic [BUFW-1:0] r = '0;
    int slot[NCH];
    int c;
    for (int k = 0; k < NCH; k++) slot[k] = 0;
    for (int i = 0; i < mq.size(); i++) begin
      c = int'(mq[i][3:2]);
      r[(c*DEPTH + slot[c])*EW +: EW] = {mq[i][1:0], 1'b1};
      slot[c]++;
    end
    return r;
  endfunction

  task automatic m_pop(input logic [1:0] c);
    e_rv = 1'b0;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i][3:2] == c) begin
        m_rd = mq[i][1:0];
        mq.delete(i);
        e_rv = 1'b1;
        break;
      end
    end
    e_rd = m_rd;
  endtask

  task automatic m_write(input logic [3:0] w);
    if (m_count(w[3:2]) == DEPTH) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i][3:2] == w[3:2]) begin
          mq.delete(i);
          break;
        end
      end
      m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    end
    mq.push_back(w);
    m_rx = (m_rx < 255) ? m_rx + 1 : 255;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; key0 = 1'b1; key1 = 1'b1; rd_en = 1'b0; rd_ch = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); m_rx = 0; m_drop = 0; m_rd = 2'd0;
    @(negedge clk);
  endtask

  task automatic arm();
    start = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // One key press; optionally pops pch three cycles after the key falls, which is the DELIVER cycle of a 4th press.
  task automatic press(input logic b, input logic pop, input logic [1:0] pch);
    if (b) key1 = 1'b0; else key0 = 1'b0;
    repeat (3) @(negedge clk);
    if (pop) begin rd_en = 1'b1; rd_ch = pch; end
    @(negedge clk);
    rd_en = 1'b0;
    s_rv = rd_valid; s_rd = rd_data; s_stb = word_stb;
    key0 = 1'b1; key1 = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_word(input logic [3:0] w, input logic pop_last, input logic [1:0] pch);
    for (int i = 3; i >= 0; i--) press(w[i], pop_last && (i == 0), pch);
    if (pop_last) m_pop(pch);
    m_write(w);
  endtask

  task automatic do_pop(input logic [1:0] c);
    rd_en = 1'b1; rd_ch = c;
    @(negedge clk);
    rd_en = 1'b0;
    s_rv = rd_valid; s_rd = rd_data;
    m_pop(c);
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++; if (word_o !== 4'h0)   begin n_fail++; $display("FAIL reset_word_o got=%0h exp=0", word_o); end
    n_chk++; if (rx_cnt !== 8'h0)   begin n_fail++; $display("FAIL reset_rx got=%0d exp=0", rx_cnt); end
    n_chk++; if (drop_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    n_chk++; if (buf_o !== '0)      begin n_fail++; $display("FAIL reset_buf got=%0h exp=0", buf_o); end
    n_chk++; if (word_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb got=%0b exp=0", word_stb); end
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
    n_chk++; if (rd_data !== 2'd0)  begin n_fail++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
  endtask

  task automatic test_basic();
    int s0;
    apply_reset(); arm();
    s0 = stb_cnt;
    send_word(4'b1011, 1'b0, 2'd0);
    n_chk++; if (word_o !== 4'b1011) begin n_fail++; $display("FAIL basic_word got=%0b exp=1011", word_o); end
    n_chk++; if (buf_o[(2*DEPTH)*EW +: EW] !== 3'b111) begin n_fail++; $display("FAIL basic_ch2_e0 got=%0b exp=111", buf_o[(2*DEPTH)*EW +: EW]); end
    n_chk++; if (buf_o !== m_buf()) begin n_fail++; $display("FAIL basic_buf got=%0h exp=%0h", buf_o, m_buf()); end
    n_chk++; if (rx_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_rx got=%0d exp=1", rx_cnt); end
    n_chk++; if (stb_cnt - s0 !== 1 || stb_dbl !== 0) begin n_fail++; $display("FAIL basic_stb pulses=%0d long=%0d exp=1,0", stb_cnt - s0, stb_dbl); end
    n_chk++; if (s_stb !== 1'b1) begin n_fail++; $display("FAIL basic_stb_timing got=%0b exp=1", s_stb); end
  endtask

  task automatic test_overflow();
    logic [1:0] pl[7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic [EW*DEPTH-1:0] exp_ch0 = {3'b101, 3'b011, 3'b001, 3'b111, 3'b101, 3'b011};
    apply_reset(); arm();
    for (int i = 0; i < 7; i++) send_word({2'b00, pl[i]}, 1'b0, 2'd0);
    n_chk++; if (buf_o[EW*DEPTH-1:0] !== exp_ch0) begin n_fail++; $display("FAIL ovf_ch0 got=%0h exp=%0h", buf_o[EW*DEPTH-1:0], exp_ch0); end
    n_chk++; if (buf_o !== m_buf()) begin n_fail++; $display("FAIL ovf_buf got=%0h exp=%0h", buf_o, m_buf()); end
    n_chk++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_drop got=%0d exp=1", drop_cnt); end
    n_chk++; if (rx_cnt !== 8'd7) begin n_fail++; $display("FAIL ovf_rx got=%0d exp=7", rx_cnt); end
  endtask

  task automatic test_pop_deliver();
    logic [1:0] p;
    apply_reset(); arm();
    for (int i = 0; i < DEPTH; i++) send_word({2'b01, 2'($urandom_range(0, 3))}, 1'b0, 2'd0);
    p = 2'($urandom_range(0, 3));
    send_word({2'b01, p}, 1'b1, 2'd1);
    n_chk++; if (s_rv !== 1'b1 || s_rd !== e_rd) begin n_fail++; $display("FAIL popdel_rd got=%0b/%0d exp=1/%0d", s_rv, s_rd, e_rd); end
    n_chk++; if (buf_o[(1*DEPTH+DEPTH-1)*EW +: EW] !== {p, 1'b1}) begin n_fail++; $display("FAIL popdel_top got=%0b exp=%0b", buf_o[(1*DEPTH+DEPTH-1)*EW +: EW], {p, 1'b1}); end
    n_chk++; if (buf_o !== m_buf()) begin n_fail++; $display("FAIL popdel_buf got=%0h exp=%0h", buf_o, m_buf()); end
    n_chk++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL popdel_drop got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_both_keys();
    int s0;
    apply_reset(); arm();
    s0 = stb_cnt;
    key0 = 1'b0; key1 = 1'b0;
    repeat (4) @(negedge clk);
    key0 = 1'b1; key1 = 1'b1;
    repeat (8) @(negedge clk);
    // key1 held counts once; key0 pressed during the hold must be ignored
    key1 = 1'b0;
    repeat (4) @(negedge clk);
    key0 = 1'b0;
    repeat (4) @(negedge clk);
    key0 = 1'b1;
    repeat (4) @(negedge clk);
    key1 = 1'b1;
    repeat (8) @(negedge clk);
    n_chk++; if (stb_cnt - s0 !== 0) begin n_fail++; $display("FAIL both_nostb pulses=%0d exp=0", stb_cnt - s0); end
    press(1'b0, 1'b0, 2'd0); press(1'b0, 1'b0, 2'd0); press(1'b1, 1'b0, 2'd0);
    m_write(4'b1001);
    n_chk++; if (word_o !== 4'b1001) begin n_fail++; $display("FAIL both_word got=%0b exp=1001", word_o); end
    n_chk++; if (stb_cnt - s0 !== 1) begin n_fail++; $display("FAIL both_stb pulses=%0d exp=1", stb_cnt - s0); end
    n_chk++; if (buf_o !== m_buf()) begin n_fail++; $display("FAIL both_buf got=%0h exp=%0h", buf_o, m_buf()); end
  endtask

  task automatic test_reset_mid();
    int s0;
    apply_reset(); arm();
    send_word(4'b1110, 1'b0, 2'd0);
    do_pop(2'd3);
    press(1'b1, 1'b0, 2'd0); press(1'b0, 1'b0, 2'd0);
    #2 rst_n = 1'b0; start = 1'b0;
    #1;
    n_chk++; if ({word_o, rx_cnt, drop_cnt, rd_data} !== '0) begin n_fail++; $display("FAIL rmid_regs got=%0h exp=0", {word_o, rx_cnt, drop_cnt, rd_data}); end
    n_chk++; if (buf_o !== '0 || word_stb !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out buf=%0h stb=%0b rv=%0b exp=0", buf_o, word_stb, rd_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); m_rx = 0; m_drop = 0; m_rd = 2'd0;
    @(negedge clk);
    arm();
    s0 = stb_cnt;
    send_word(4'b0110, 1'b0, 2'd0);
    n_chk++; if (word_o !== 4'b0110) begin n_fail++; $display("FAIL rmid_word got=%0b exp=0110", word_o); end
    n_chk++; if (rx_cnt !== 8'd1 || stb_cnt - s0 !== 1) begin n_fail++; $display("FAIL rmid_rx rx=%0d pulses=%0d exp=1,1", rx_cnt, stb_cnt - s0); end
    n_chk++; if (buf_o !== m_buf()) begin n_fail++; $display("FAIL rmid_buf got=%0h exp=%0h", buf_o, m_buf()); end
  endtask

  task automatic test_pop_empty();
    apply_reset(); arm();
    send_word(4'b0010, 1'b0, 2'd0);
    do_pop(2'd0);
    n_chk++; if (s_rv !== 1'b1 || s_rd !== 2'd2) begin n_fail++; $display("FAIL pe_first got=%0b/%0d exp=1/2", s_rv, s_rd); end
    do_pop(2'd3);
    n_chk++; if (s_rv !== 1'b0) begin n_fail++; $display("FAIL pe_valid got=%0b exp=0", s_rv); end
    n_chk++; if (s_rd !== 2'd2) begin n_fail++; $display("FAIL pe_hold got=%0d exp=2", s_rd); end
    n_chk++; if (buf_o !== m_buf()) begin n_fail++; $display("FAIL pe_buf got=%0h exp=%0h", buf_o, m_buf()); end
  endtask

  task automatic test_abort();
    apply_reset(); arm();
    press(1'b1, 1'b0, 2'd0); press(1'b1, 1'b0, 2'd0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    arm();
    send_word(4'b0001, 1'b0, 2'd0);
    n_chk++; if (word_o !== 4'b0001) begin n_fail++; $display("FAIL abort_word got=%0b exp=0001", word_o); end
    n_chk++; if (buf_o !== m_buf() || rx_cnt !== 8'd1) begin n_fail++; $display("FAIL abort_buf got=%0h rx=%0d exp=%0h rx=1", buf_o, rx_cnt, m_buf()); end
  endtask

  task automatic test_random();
    logic [3:0] w;
    logic       pl;
    logic [1:0] pc;
    apply_reset(); arm();
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 2) begin
        w  = 4'($urandom_range(0, 15));
        pl = 1'($urandom_range(0, 1));
        pc = 2'($urandom_range(0, 3));
        send_word(w, pl, pc);
        n_chk++; if (word_o !== w) begin n_fail++; $display("FAIL rnd_word it=%0d got=%0h exp=%0h", it, word_o, w); end
        if (pl) begin
          n_chk++; if (s_rv !== e_rv || s_rd !== e_rd) begin n_fail++; $display("FAIL rnd_popdel it=%0d got=%0b/%0d exp=%0b/%0d", it, s_rv, s_rd, e_rv, e_rd); end
        end
      end else begin
        pc = 2'($urandom_range(0, 3));
        do_pop(pc);
        n_chk++; if (s_rv !== e_rv || s_rd !== e_rd) begin n_fail++; $display("FAIL rnd_pop it=%0d got=%0b/%0d exp=%0b/%0d", it, s_rv, s_rd, e_rv, e_rd); end
      end
      n_chk++; if (buf_o !== m_buf()) begin n_fail++; $display("FAIL rnd_buf it=%0d got=%0h exp=%0h", it, buf_o, m_buf()); end
      n_chk++; if (rx_cnt !== 8'(m_rx) || drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL rnd_cnt it=%0d got=%0d/%0d exp=%0d/%0d", it, rx_cnt, drop_cnt, m_rx, m_drop); end
    end
  endtask

  task automatic test_saturate();
    apply_reset(); arm();
    for (int i = 0; i < 262; i++) send_word({2'b11, 2'($urandom_range(0, 3))}, 1'b0, 2'd0);
    n_chk++; if (rx_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_rx got=%0d exp=255", rx_cnt); end
    n_chk++; if (drop_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_drop got=%0d exp=255", drop_cnt); end
    n_chk++; if (buf_o !== m_buf()) begin n_fail++; $display("FAIL sat_buf got=%0h exp=%0h", buf_o, m_buf()); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; key0 = 1'b1; key1 = 1'b1; rd_en = 1'b0; rd_ch = 2'd0;
    test_reset();
    test_basic();
    test_overflow();
    test_pop_deliver();
    test_both_keys();
    test_reset_mid();
    test_pop_empty();
    test_abort();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_router.md
SERIAL_ROUTER -- requirements
Module: serial_router

Interface
REQ-001 Parameter CH_BITS, default 2: channel-select bits; NCH = 2**CH_BITS channels.
REQ-002 Parameter PAY_W, default 2: payload bits per word; word width W = CH_BITS+PAY_W.
REQ-003 Parameter DEPTH, default 6: entries per channel buffer, DEPTH >= 2.
REQ-004 Parameter ARM_CYC, default 3: cycles between start and first accepted bit.
REQ-005 Parameter CNT_W, default 8: width of the drop and receive counters.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 start  input  1  level; high arms word entry.
REQ-009 key0  input  1  button, active-low (0 when pushed); a press enters bit 0.
REQ-010 key1  input  1  button, active-low (0 when pushed); a press enters bit 1.
REQ-011 rd_en  input  1  pop request for channel rd_ch.
REQ-012 rd_ch  input  CH_BITS  channel to pop.
REQ-013 rd_data  output  PAY_W  popped payload, registered.
REQ-014 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-015 buf_o  output  NCH*DEPTH*(PAY_W+1)  flattened buffers; channel c entry e at LSB offset (c*DEPTH+e)*(PAY_W+1); each entry = {payload, valid}.
REQ-016 word_o  output  W  last assembled word; word_stb  output  1  one-cycle pulse at delivery.
REQ-017 drop_cnt  output  CNT_W  words discarded by overflow; rx_cnt  output  CNT_W  words delivered.

Function
REQ-018 key0/key1 SHALL pass through 2-flop synchronisers; a press = synchronised key 1->0 transition while the other synchronised key is 1.
REQ-019 Press on both keys in the same cycle, or press of one key while the other is held, SHALL be ignored (no bit).
REQ-020 FSM states IDLE, ARM, COLLECT, DELIVER; IDLE->ARM when start=1.
REQ-021 ARM SHALL last exactly ARM_CYC cycles then go to COLLECT; start=0 in ARM or COLLECT returns to IDLE and discards partial bits.
REQ-022 Presses outside COLLECT SHALL be ignored.
REQ-023 In COLLECT each press SHALL shift its bit in MSB-first; after the W-th bit the FSM enters DELIVER next cycle.
REQ-024 DELIVER (one cycle): word_o <= word, word_stb=1, write to channel word[W-1:PAY_W] with payload word[PAY_W-1:0]; next state ARM if start=1, else IDLE.
REQ-025 Buffers: entry 0 oldest; occupied entries contiguous from 0; unoccupied entries all zero.
REQ-026 Write to non-full channel with n entries SHALL place {payload,1} at entry n.
REQ-027 Write to full channel SHALL shift entries down by one (oldest lost), place new at DEPTH-1, drop_cnt +1.
REQ-028 Pop on non-empty channel: rd_data = entry 0 payload and rd_valid=1 on next cycle; entries shift down, top cleared.
REQ-029 Pop on empty channel: rd_valid=0, rd_data holds, no state change.
REQ-030 Pop and write to same full channel in the same cycle: pop first, then write; no drop.
REQ-031 Pop and write to different channels in the same cycle: both proceed independently.
REQ-032 rx_cnt +1 per DELIVER; drop_cnt and rx_cnt SHALL saturate at all-ones.
REQ-033 Buffer update SHALL be visible on buf_o the cycle after DELIVER.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, clear all buffers, synchronisers to 1, word_o, rd_data, counters to 0, word_stb and rd_valid to 0.
REQ-035 Reset mid-COLLECT SHALL discard the partial word; after release, entry restarts with start.

Verification
REQ-036 start=1 held, after ARM presses key1,key0,key1,key1 -> word_o=4'b1011, channel 2 entry 0 = 3'b111, rx_cnt=1, word_stb single pulse.
REQ-037 Seven words to channel 0, payloads 0,1,2,3,0,1,2 -> channel 0 entries 0..5 = payloads 1,2,3,0,1,2 all valid, drop_cnt=1, rx_cnt=7.
REQ-038 Channel 1 full, pop ch1 in DELIVER cycle of a ch1 word -> rd_valid=1 with oldest payload, channel stays full with new word at entry 5, drop_cnt unchanged.
REQ-039 Both keys pressed same cycle during COLLECT -> no bit shifted, no word_stb; next valid 4 presses assemble normally.
REQ-040 rst_n pulsed low after 2 presses -> all outputs zero; after release and ARM, 4 presses deliver the new word only.
REQ-041 Pop on empty channel 3 -> rd_valid=0, buf_o unchanged.
